gamma_dither: RTL and testbench
===============================

GAMMA_DITHER -- requirements
Module: gamma_dither

Interface
REQ-001 The block SHALL have parameter VS_POL, default 1, meaning the active level of I_vs (1 = active-high, 0 = active-low).
REQ-002 The block SHALL have port I_clk, input, 1 bit: pixel clock; all logic is on the rising edge.
REQ-003 The block SHALL have port I_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports I_vs, I_hs and I_de, input, 1 bit each: video timing aligned with the input data.
REQ-005 The block SHALL have ports I_r_data, I_g_data and I_b_data, input, 12 bits each: gamma-corrected channel values from the gamma LUT stage.
REQ-006 The block SHALL have ports O_vs, O_hs and O_de, output, 1 bit each: timing delayed to match the output data.
REQ-007 The block SHALL have ports O_r_data, O_g_data and O_b_data, output, 8 bits each: dithered 8-bit channel values.

Function
REQ-008 The block SHALL reduce each 12-bit channel to 8 bits using a 4x4 ordered (Bayer) dither.
REQ-009 The threshold table t[y][x] SHALL be: row 0 = 0 8 2 10; row 1 = 12 4 14 6; row 2 = 3 11 1 9; row 3 = 15 7 13 5.
REQ-010 Column counter x[1:0] SHALL increment on each cycle with I_de=1 and SHALL clear to 0 on each cycle with I_de=0.
REQ-011 Row counter y[1:0] SHALL increment, wrapping 3 to 0, on each I_de falling edge (I_de=0 while the registered I_de=1).
REQ-012 Row counter y SHALL clear to 0 on the rising edge of the active I_vs level defined by VS_POL.
REQ-013 If an I_vs active edge and an I_de falling edge occur in the same cycle, y SHALL clear to 0; the clear wins.
REQ-014 Stage 1 SHALL register, per channel, the 13-bit sum = {1'b0, I_x_data} + t[y][x], using the x and y values current in the input cycle.
REQ-015 Stage 2 SHALL register, per channel, 255 if sum[12]=1, else sum[11:4].
REQ-016 When the stage-2 de is 0, all three output data buses SHALL be forced to 0.
REQ-017 Latency from input to output SHALL be exactly 2 clocks for data, vs, hs and de alike; there is no back-pressure.
REQ-018 The three channels SHALL use the same t[y][x] in any given cycle.

Reset
REQ-019 While I_rst=1, all outputs, pipeline registers, x, y and the edge-detect registers SHALL be 0, asynchronously.
REQ-020 After I_rst deasserts mid-frame, counting SHALL restart from x=0, y=0.
REQ-021 After I_rst deasserts mid-frame, outputs SHALL follow the inputs after 2 clocks; no recovery of frame position is required.

Configuration
REQ-022 Macro GAMMA_DITHER_EN defined: the block SHALL use the dither behaviour of REQ-008 to REQ-018.
REQ-023 Macro GAMMA_DITHER_EN undefined: t[y][x] SHALL be replaced by the constant 8, giving plain round-to-nearest with saturation.
REQ-024 Macro GAMMA_DITHER_EN undefined: the x and y counters SHALL be omitted; latency and reset behaviour SHALL be unchanged.

Verification
REQ-025 The bench SHALL cover saturation: a flat frame of 4090 on all channels -> every active output = 255, no wrap to 0.
REQ-026 The bench SHALL cover zero input: a flat frame of 0 -> every active output = 0 in both macro builds.
REQ-027 The bench SHALL cover the dither pattern (macro on): a flat value of 8 -> row 0 outputs 0,1,0,1; row 1 outputs 1,0,1,0; the pattern repeats every 4 lines and resets to row 0 after a vs edge.
REQ-028 The bench SHALL cover rounding (macro off): input 7 -> 0; input 8 -> 1; input 2039 -> 127; input 2040 -> 128.
REQ-029 The bench SHALL cover latency and blanking: a single-cycle I_de pulse with data 0x800 and I_hs toggling -> O_de, O_hs and O_data=128 (macro off) all appear exactly 2 clocks later; O_data = 0 whenever O_de = 0.
REQ-030 The bench SHALL cover reset mid-line: I_rst asserted for 1 cycle during active video -> all outputs go to 0 immediately, and the next dithered pixels use t[0][0] onward.

Source files
------------

// File: rtl/gamma_dither.sv
// gamma_dither: 12-bit to 8-bit channel reduction with optional 4x4 ordered dither
// Build option: define GAMMA_DITHER_EN for the Bayer dither; otherwise round-to-nearest with saturation.
// Ports: I_clk/I_rst (async active-high); I_vs/I_hs/I_de + I_{r,g,b}_data[11:0] in;
//        O_vs/O_hs/O_de + O_{r,g,b}_data[7:0] out, 2-clock latency, data zero outside de.
module gamma_dither #(
    parameter bit VS_POL = 1'b1
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_vs,
    input  logic        I_hs,
    input  logic        I_de,
    input  logic [11:0] I_r_data,
    input  logic [11:0] I_g_data,
    input  logic [11:0] I_b_data,
    output logic        O_vs,
    output logic        O_hs,
    output logic        O_de,
    output logic [7:0]  O_r_data,
    output logic [7:0]  O_g_data,
    output logic [7:0]  O_b_data
);
    logic [3:0]  th;
    logic [12:0] r1, g1, b1;
    logic        vs1, hs1, de1;
`ifdef GAMMA_DITHER_EN
    // t[y][x] packed as nibbles, index {y,x}; entry 0 in the low nibble
    localparam logic [63:0] BAYER = 64'h5D7F91B36E4CA280;
    logic [1:0] x, y;
    logic       de_q, vs_q, vs_act, vs_rise, de_fall;
    assign vs_act  = VS_POL ? I_vs : ~I_vs;
    assign vs_rise = vs_act & ~vs_q;
    assign de_fall = ~I_de & de_q;
    assign th      = BAYER[{y, x, 2'b00} +: 4];
    always_ff @(posedge I_clk or posedge I_rst)
        if (I_rst) begin
            x    <= 2'd0;
            y    <= 2'd0;
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            x    <= I_de ? x + 2'd1 : 2'd0;
            y    <= vs_rise ? 2'd0 : de_fall ? y + 2'd1 : y;
            de_q <= I_de;
            vs_q <= vs_act;
        end
`else
    logic unused_vs_pol;
    assign unused_vs_pol = VS_POL;
    assign th            = 4'd8;
`endif
    function automatic logic [7:0] sat(input logic [12:0] s);
        return s[12] ? 8'hFF : s[11:4];
    endfunction
    always_ff @(posedge I_clk or posedge I_rst)
        if (I_rst) begin
            r1       <= 13'd0;
            g1       <= 13'd0;
            b1       <= 13'd0;
            vs1      <= 1'b0;
            hs1      <= 1'b0;
            de1      <= 1'b0;
            O_vs     <= 1'b0;
            O_hs     <= 1'b0;
            O_de     <= 1'b0;
            O_r_data <= 8'd0;
            O_g_data <= 8'd0;
            O_b_data <= 8'd0;
        end else begin
            r1       <= {1'b0, I_r_data} + {9'd0, th};
            g1       <= {1'b0, I_g_data} + {9'd0, th};
            b1       <= {1'b0, I_b_data} + {9'd0, th};
            vs1      <= I_vs;
            hs1      <= I_hs;
            de1      <= I_de;
            O_vs     <= vs1;
            O_hs     <= hs1;
            O_de     <= de1;
            O_r_data <= de1 ? sat(r1) : 8'd0;
            O_g_data <= de1 ? sat(g1) : 8'd0;
            O_b_data <= de1 ? sat(b1) : 8'd0;
        end
endmodule

// File: tb/tb_gamma_dither.sv
// tb_gamma_dither: randomized and directed checks of gamma_dither against a pixel-level model
module tb_gamma_dither;
    logic        I_clk = 1'b0, I_rst = 1'b0, I_vs = 1'b0, I_hs = 1'b0, I_de = 1'b0;
    logic [11:0] I_r_data = 12'd0, I_g_data = 12'd0, I_b_data = 12'd0;
    logic        O_vs, O_hs, O_de;
    logic [7:0]  O_r_data, O_g_data, O_b_data;
    int checks = 0, errors = 0;
    typedef struct {
        int vs, hs, de, r, g, b;
    } px_t;
    px_t p1, p2, zero_px;
    int col = 0, row = 0, pd = 0, pv = 0;
`ifdef GAMMA_DITHER_EN
    int t_tab[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
`else
    int t_tab[4][4] = '{default: '{default: 8}};
`endif

    gamma_dither dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_vs(I_vs), .I_hs(I_hs), .I_de(I_de),
        .I_r_data(I_r_data), .I_g_data(I_g_data), .I_b_data(I_b_data),
        .O_vs(O_vs), .O_hs(O_hs), .O_de(O_de),
        .O_r_data(O_r_data), .O_g_data(O_g_data), .O_b_data(O_b_data)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int quant(input int v, input int t);
        int s = (v + t) / 16;
        return s > 255 ? 255 : s;
    endfunction

    function automatic int pick(input int v);
        return v < 0 ? int'($urandom_range(0, 4095)) : v;
    endfunction

    task automatic chk_out(input px_t e);
        chk("vs", O_vs, e.vs);
        chk("hs", O_hs, e.hs);
        chk("de", O_de, e.de);
        chk("r", O_r_data, e.r);
        chk("g", O_g_data, e.g);
        chk("b", O_b_data, e.b);
    endtask

    task automatic cyc(input int de, input int hs, input int vs, input int r, input int g, input int b);
        px_t cur;
        int  t = t_tab[row][col % 4];
        I_de = 1'(de); I_hs = 1'(hs); I_vs = 1'(vs);
        I_r_data = 12'(r); I_g_data = 12'(g); I_b_data = 12'(b);
        cur.vs = vs; cur.hs = hs; cur.de = de;
        cur.r = de ? quant(r, t) : 0;
        cur.g = de ? quant(g, t) : 0;
        cur.b = de ? quant(b, t) : 0;
        @(posedge I_clk);
        #1;
        if (vs && !pv) row = 0;
        else if (!de && pd) row = (row + 1) % 4;
        col = de ? col + 1 : 0;
        pd = de;
        pv = vs;
        p2 = p1;
        p1 = cur;
        chk_out(p2);
    endtask

    task automatic do_reset();
        I_rst = 1'b1;
        #1;
        chk_out(zero_px);
        @(posedge I_clk);
        #1;
        chk_out(zero_px);
        I_rst = 1'b0;
        p1 = zero_px; p2 = zero_px;
        col = 0; row = 0; pd = 0; pv = 0;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) cyc(0, i == 0, 0, pick(-1), pick(-1), pick(-1));
    endtask

    task automatic vsync();
        for (int i = 0; i < 4; i++) cyc(0, 0, i < 2, pick(-1), pick(-1), pick(-1));
    endtask

    task automatic line(input int n, input int v);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, pick(v), pick(v), pick(v));
        blank(3);
    endtask

    task automatic frame(input int lines, input int n, input int v);
        vsync();
        for (int l = 0; l < lines; l++) line(n, v);
    endtask

    initial begin
        do_reset();
        frame(5, 6, 4090);
        frame(2, 5, 0);
        frame(5, 4, 8);
        frame(2, 4, 8);
        vsync();
        cyc(1, 0, 0, 7, 7, 7);
        cyc(1, 0, 0, 8, 8, 8);
        cyc(1, 0, 0, 2039, 2039, 2039);
        cyc(1, 0, 0, 2040, 2040, 2040);
        cyc(1, 0, 0, 7, 2039, 4095);
        blank(4);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 12'h800, 12'h800, 12'h800);
        cyc(0, 0, 0, 12'h800, 12'h800, 12'h800);
        cyc(0, 1, 0, 12'h800, 12'h800, 12'h800);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        frame(1, 5, 8);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8, 8, 8);
        do_reset();
        line(6, 8);
        line(6, 8);
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 40) == 0,
                pick(-1), pick(-1), pick(-1));
        vsync();
        line(5, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
